// File: rtl/input_arbiter.sv
// Merges NUM_SRC controller sources into one registered button vector with manual select or auto-lock.
// Build option: define SOCD_CLEAN_EN to cancel opposing directions (Up+Down, Left+Right) before registering.
module input_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int NUM_BTN     = 4,
    parameter int SEL_W       = $clog2(NUM_SRC),
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Mode,
    input  logic [SEL_W-1:0]           Choice,
    input  logic [NUM_SRC*NUM_BTN-1:0] Btn,
    input  logic [NUM_SRC-1:0]         Readable,
    output logic [NUM_BTN-1:0]         Out,
    output logic [NUM_BTN-1:0]         Press,
    output logic [SEL_W-1:0]           Active,
    output logic                       Valid,
    output logic                       State
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [SEL_W-1:0] LAST_SRC  = SEL_W'(NUM_SRC - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q;

    logic [NUM_BTN-1:0] out_d;
    logic               valid_d;
    logic [SEL_W-1:0]   active_d;

    logic [NUM_BTN-1:0] src_btn [NUM_SRC];
    logic               cand_found;
    logic [SEL_W-1:0]   cand_idx;
    logic [SEL_W-1:0]   man_sel;
    logic [NUM_BTN-1:0] owner_btn;

    // Opposing-direction cancellation; padded copy keeps the bit indices legal for narrow NUM_BTN.
    function automatic logic [NUM_BTN-1:0] socd_clean(input logic [NUM_BTN-1:0] v);
        logic [NUM_BTN+3:0] w;
        w = {4'b0000, v};
`ifdef SOCD_CLEAN_EN
        if (NUM_BTN >= 4) begin
            if (w[0] && w[1]) begin
                w[0] = 1'b0;
                w[1] = 1'b0;
            end
            if (w[2] && w[3]) begin
                w[2] = 1'b0;
                w[3] = 1'b0;
            end
        end
`endif
        return w[NUM_BTN-1:0];
    endfunction

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_btn[s] = Btn[s*NUM_BTN +: NUM_BTN];
        end
    end

    // Scan from the top so the lowest-index claimant wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (Readable[s] && (|src_btn[s])) begin
                cand_found = 1'b1;
                cand_idx   = SEL_W'(s);
            end
        end
    end

    always_comb begin
        man_sel = (int'(Choice) >= NUM_SRC) ? LAST_SRC : Choice;
    end

    assign owner_btn = src_btn[owner_q];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        out_d    = '0;
        valid_d  = 1'b0;
        active_d = Active;

        if (Mode != mode_q) begin
            // One blank cycle on any mode switch; Active keeps its last value.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!Mode) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            active_d = man_sel;
            if (Readable[man_sel]) begin
                out_d   = socd_clean(src_btn[man_sel]);
                valid_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_found) begin
                        owner_d  = cand_idx;
                        active_d = cand_idx;
                        out_d    = socd_clean(src_btn[cand_idx]);
                        valid_d  = 1'b1;
                        state_d  = ST_LOCKED;
                        cnt_d    = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!Readable[owner_q]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        out_d    = socd_clean(owner_btn);
                        valid_d  = 1'b1;
                        active_d = owner_q;
                        if (|owner_btn) begin
                            cnt_d = '0;
                        end else if (cnt_q == HOLD_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            Out     <= '0;
            Press   <= '0;
            Active  <= '0;
            Valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            mode_q  <= Mode;
            Out     <= out_d;
            Press   <= out_d & ~Out;
            Active  <= active_d;
            Valid   <= valid_d;
        end
    end

    assign State = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_input_arbiter.sv
// Scoreboard bench for input_arbiter: manual select, auto-lock, hold timeout, mode switch and SOCD cleaning.
module tb_input_arbiter;

    localparam int NUM_SRC     = 3;
    localparam int NUM_BTN     = 4;
    localparam int SEL_W       = 2;
    localparam int HOLD_CYCLES = 4;
    localparam int W           = 12;
`ifdef SOCD_CLEAN_EN
    localparam bit SOCD = 1'b1;
`else
    localparam bit SOCD = 1'b0;
`endif

    logic                       CLK;
    logic                       RST;
    logic                       Mode;
    logic [SEL_W-1:0]           Choice;
    logic [NUM_SRC*NUM_BTN-1:0] Btn;
    logic [NUM_SRC-1:0]         Readable;
    logic [NUM_BTN-1:0]         Out;
    logic [NUM_BTN-1:0]         Press;
    logic [SEL_W-1:0]           Active;
    logic                       Valid;
    logic                       State;

    logic [W-1:0]       exp_q[$];
    logic [NUM_BTN-1:0] prev_out;
    int                 n_checks;
    int                 n_errors;
    int                 step_no;

    input_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .NUM_BTN    (NUM_BTN),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Mode    (Mode),
        .Choice  (Choice),
        .Btn     (Btn),
        .Readable(Readable),
        .Out     (Out),
        .Press   (Press),
        .Active  (Active),
        .Valid   (Valid),
        .State   (State)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at step %0d", step_no);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pk(input logic [3:0] s2, input logic [3:0] s1, input logic [3:0] s0);
        return {s2, s1, s0};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input logic rst, input logic mode, input logic [1:0] ch,
                        input logic [11:0] btn, input logic [2:0] rd,
                        input logic [3:0] e_out, input logic e_valid,
                        input logic [1:0] e_active, input logic e_state);
        logic [3:0]   e_press;
        logic [W-1:0] e;
        RST      = rst;
        Mode     = mode;
        Choice   = ch;
        Btn      = btn;
        Readable = rd;
        e_press  = rst ? 4'h0 : (e_out & ~prev_out);
        prev_out = rst ? 4'h0 : e_out;
        exp_q.push_back({e_out, e_press, e_active, e_valid, e_state});
        @(posedge CLK);
        #1;
        step_no++;
        e = exp_q.pop_front();
        check($sformatf("s%0d_out", step_no),    32'(Out),    32'(e[11:8]));
        check($sformatf("s%0d_press", step_no),  32'(Press),  32'(e[7:4]));
        check($sformatf("s%0d_active", step_no), 32'(Active), 32'(e[3:2]));
        check($sformatf("s%0d_valid", step_no),  32'(Valid),  32'(e[1]));
        check($sformatf("s%0d_state", step_no),  32'(State),  32'(e[0]));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        step_no  = 0;
        prev_out = '0;
        RST      = 1'b1;
        Mode     = 1'b0;
        Choice   = '0;
        Btn      = '1;
        Readable = '1;

        // Reset held two cycles with every button pressed
        step(1, 0, 0, 12'hFFF, 3'b111, 4'h0, 0, 0, 0);
        step(1, 0, 0, 12'hFFF, 3'b111, 4'h0, 0, 0, 0);
        // Release: Out rises, Press for exactly one cycle
        step(0, 0, 0, 12'hFFF, 3'b111, 4'hF, 1, 0, 0);
        step(0, 0, 0, 12'hFFF, 3'b111, 4'hF, 1, 0, 0);

        // Manual: out-of-range Choice clamps to the last source
        step(0, 0, 3, pk(4'b0101, 4'hF, 4'hF), 3'b100, 4'b0101, 1, 2, 0);
        step(0, 0, 3, pk(4'b0101, 4'hF, 4'hF), 3'b000, 4'b0000, 0, 2, 0);
        step(0, 0, 1, pk(4'b0101, 4'b0110, 4'hF), 3'b010, 4'b0110, 1, 1, 0);
        step(0, 0, 2, pk(4'b1010, 4'b0110, 4'hF), 3'b111, 4'b1010, 1, 2, 0);

        // Switch to auto: blank cycle, then simultaneous claim goes to src1
        step(0, 1, 0, 12'h000, 3'b111, 4'b0000, 0, 2, 0);
        step(0, 1, 0, pk(4'b0001, 4'b0001, 4'b0000), 3'b111, 4'b0001, 1, 1, 1);
        step(0, 1, 0, pk(4'b1000, 4'b0001, 4'b0000), 3'b111, 4'b0001, 1, 1, 1);

        // Owner src1 released: four idle cycles then unlock, src2 ignored meanwhile
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 1, 1);
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 1, 1);
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 1, 1);
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 1, 0);
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0000), 3'b111, 4'b1000, 1, 2, 1);

        // Owner loses Readable: blank cycle, no claim, then src0 takes over
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0001), 3'b011, 4'b0000, 0, 2, 0);
        step(0, 1, 0, pk(4'b1000, 4'b0000, 4'b0001), 3'b011, 4'b0001, 1, 0, 1);

        // Hold counter restarts on a re-press, then expires after four released cycles
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 0, 1);
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0100), 3'b111, 4'b0100, 1, 0, 1);
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 0, 1);
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 0, 1);
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 0, 1);
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0000), 3'b111, 4'b0000, 1, 0, 0);
        step(0, 1, 0, pk(4'b0010, 4'b0000, 4'b0000), 3'b111, 4'b0010, 1, 2, 1);

        // Readable drop while another source is pressed
        step(0, 1, 0, pk(4'b0010, 4'b0001, 4'b0000), 3'b011, 4'b0000, 0, 2, 0);
        step(0, 1, 0, pk(4'b0010, 4'b0001, 4'b0000), 3'b011, 4'b0001, 1, 1, 1);

        // Back to manual while locked
        step(0, 0, 0, pk(4'b0000, 4'b0000, 4'b0101), 3'b111, 4'b0000, 0, 1, 0);
        step(0, 0, 0, pk(4'b0000, 4'b0000, 4'b0101), 3'b111, 4'b0101, 1, 0, 0);

        // Opposing directions
        step(0, 0, 0, pk(4'b0000, 4'b0000, 4'b1111), 3'b111, SOCD ? 4'b0000 : 4'b1111, 1, 0, 0);
        step(0, 0, 0, pk(4'b0000, 4'b0000, 4'b0011), 3'b111, SOCD ? 4'b0000 : 4'b0011, 1, 0, 0);
        step(0, 0, 0, pk(4'b0000, 4'b0000, 4'b0011), 3'b000, 4'b0000, 0, 0, 0);

        // Auto with no candidate keeps Active; unreadable src2 cannot claim
        step(0, 1, 0, 12'h000, 3'b111, 4'b0000, 0, 0, 0);
        step(0, 1, 0, 12'h000, 3'b111, 4'b0000, 0, 0, 0);
        step(0, 1, 0, pk(4'b0100, 4'b0001, 4'b0000), 3'b011, 4'b0001, 1, 1, 1);

        // Reset wins over active input
        step(1, 1, 0, pk(4'b0100, 4'b0001, 4'b0000), 3'b011, 4'b0000, 0, 0, 0);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
